// File: rtl/m16_pkg.sv
// Shared constants and FSM encoding for the M16 frame-buffer write side.
package m16_pkg;
  localparam int unsigned BANK_WORDS = 2048;
  localparam int unsigned WORD_W     = 12;
  localparam int unsigned ADDR_W     = 11;
  localparam int unsigned MARK_BIT   = 11;

  typedef enum logic {
    RUN,
    SWAP
  } state_t;
endpackage

// File: rtl/m16_fill_ptr.sv
// Fill pointer for one buffer region: counts accepted words up to DEPTH,
// clears on a bank swap, and reports full / short status.
module m16_fill_ptr
  import m16_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic              iClkOrb,
  input  logic              reset,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr,
  output logic              full,
  output logic              shortFlag
);

  // full is kept as its own flop so it tracks ptr without a wide compare on the output path
  always_ff @(posedge iClkOrb) begin
    if (!reset) begin
      ptr  <= '0;
      full <= 1'b0;
    end else if (clr) begin
      ptr  <= '0;
      full <= 1'b0;
    end else if (inc && !full) begin
      ptr  <= ptr + 1'b1;
      full <= (ptr == ADDR_W'(DEPTH - 1));
    end
  end

  assign shortFlag = ~full;

endmodule

// File: rtl/m16_fill_arb.sv
// Write-side scheduler for the M16 dual-bank frame buffer: arbitrates fast/slow
// producers into the idle bank. Optional feature: M16_FILL_MARKER_EN.
module m16_fill_arb #(
  parameter int unsigned FAST_WORDS = 1536,
  parameter int unsigned STARVE     = 4
) (
  input  logic        iClkOrb,
  input  logic        reset,
  input  logic        iSwitch,
  input  logic        iFastVal,
  input  logic [11:0] iFastData,
  output logic        oFastRdy,
  input  logic        iSlowVal,
  input  logic [11:0] iSlowData,
  output logic        oSlowRdy,
  output logic        oWrEn,
  output logic [11:0] oWrAddr,
  output logic [11:0] oWrData,
  output logic        oFull,
  output logic        oFastShort,
  output logic        oSlowShort
`ifdef M16_FILL_MARKER_EN
  ,
  output logic        oMarkErr
`endif
);
  import m16_pkg::*;

  localparam int unsigned SLOW_WORDS = BANK_WORDS - FAST_WORDS;

  state_t              state, stateNext;
  logic                swReg;
  logic [ADDR_W-1:0]   fPtr, sPtr;
  logic                fFull, sFull, fShort, sShort;
  logic [2:0]          starveCnt;
  logic                swapEvt, fastOk, slowOk, fastGnt, slowGnt;
  logic [ADDR_W-1:0]   wrOff;
  logic [WORD_W-1:0]   wrWord;

  always_ff @(posedge iClkOrb) begin
    if (!reset) state <= RUN;
    else        state <= stateNext;
  end

  always_comb begin
    swapEvt   = (iSwitch != swReg);
    fastOk    = iFastVal & ~fFull;
    slowOk    = iSlowVal & ~sFull;
    fastGnt   = 1'b0;
    slowGnt   = 1'b0;
    stateNext = state;
    case (state)
      RUN:     if (swapEvt) stateNext = SWAP;
      SWAP:    stateNext = swapEvt ? SWAP : RUN;
      default: stateNext = RUN;
    endcase
    // grants are suppressed while reset is held so no handshake can complete into a discarded state
    if (reset && !swapEvt) begin
      slowGnt = slowOk & (~fastOk | (starveCnt == 3'(STARVE - 1)));
      fastGnt = fastOk & ~slowGnt;
    end
    wrOff  = slowGnt ? (ADDR_W'(FAST_WORDS) + sPtr) : fPtr;
    wrWord = slowGnt ? iSlowData : iFastData;
`ifdef M16_FILL_MARKER_EN
    wrWord[MARK_BIT] = 1'b0;
`endif
  end

  assign oFastRdy = fastGnt;
  assign oSlowRdy = slowGnt;
  assign oFull    = fFull & sFull;

  m16_fill_ptr #(.DEPTH(FAST_WORDS)) uFastPtr (
    .iClkOrb  (iClkOrb),
    .reset    (reset),
    .clr      (swapEvt),
    .inc      (fastGnt),
    .ptr      (fPtr),
    .full     (fFull),
    .shortFlag(fShort)
  );

  m16_fill_ptr #(.DEPTH(SLOW_WORDS)) uSlowPtr (
    .iClkOrb  (iClkOrb),
    .reset    (reset),
    .clr      (swapEvt),
    .inc      (slowGnt),
    .ptr      (sPtr),
    .full     (sFull),
    .shortFlag(sShort)
  );

  always_ff @(posedge iClkOrb) begin
    if (!reset) begin
      swReg      <= 1'b0;
      starveCnt  <= '0;
      oWrEn      <= 1'b0;
      oWrAddr    <= '0;
      oWrData    <= '0;
      oFastShort <= 1'b0;
      oSlowShort <= 1'b0;
    end else begin
      swReg      <= iSwitch;
      oFastShort <= swapEvt & fShort;
      oSlowShort <= swapEvt & sShort;
      oWrEn      <= fastGnt | slowGnt;
      if (fastGnt || slowGnt) begin
        oWrAddr <= {~swReg, wrOff};
        oWrData <= wrWord;
      end
      if (swapEvt || slowGnt || !slowOk) starveCnt <= '0;
      else if (fastGnt)                  starveCnt <= starveCnt + 1'b1;
    end
  end

`ifdef M16_FILL_MARKER_EN
  always_ff @(posedge iClkOrb) begin
    if (!reset) oMarkErr <= 1'b0;
    else        oMarkErr <= slowGnt ? iSlowData[MARK_BIT] : (fastGnt & iFastData[MARK_BIT]);
  end
`endif

endmodule

// File: tb/tb_m16_fill_arb.sv
// Self-checking bench for m16_fill_arb: directed vector table, long directed
// fill/swap sequences and randomized traffic against a counting reference model.
module tb_m16_fill_arb;
  localparam int FAST   = 1536;
  localparam int SLOW   = 2048 - FAST;
  localparam int STARVE = 4;

  logic        iClkOrb = 1'b0;
  logic        reset = 1'b0;
  logic        iSwitch = 1'b0;
  logic        iFastVal = 1'b0;
  logic [11:0] iFastData = '0;
  logic        iSlowVal = 1'b0;
  logic [11:0] iSlowData = '0;
  logic        oFastRdy, oSlowRdy, oWrEn, oFull, oFastShort, oSlowShort;
  logic [11:0] oWrAddr, oWrData;
`ifdef M16_FILL_MARKER_EN
  logic        oMarkErr;
`endif

  always #5 iClkOrb = ~iClkOrb;

  m16_fill_arb #(.FAST_WORDS(FAST), .STARVE(STARVE)) dut (
    .iClkOrb   (iClkOrb),
    .reset     (reset),
    .iSwitch   (iSwitch),
    .iFastVal  (iFastVal),
    .iFastData (iFastData),
    .oFastRdy  (oFastRdy),
    .iSlowVal  (iSlowVal),
    .iSlowData (iSlowData),
    .oSlowRdy  (oSlowRdy),
    .oWrEn     (oWrEn),
    .oWrAddr   (oWrAddr),
    .oWrData   (oWrData),
    .oFull     (oFull),
    .oFastShort(oFastShort),
    .oSlowShort(oSlowShort)
`ifdef M16_FILL_MARKER_EN
    ,
    .oMarkErr  (oMarkErr)
`endif
  );

  int nChecks = 0;
  int nFail   = 0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word counts per region, run length of fast wins over a waiting slow word
  int fCnt, sCnt, run;
  bit swPrev;
  bit eWrEn, eFS, eSS, eFull, eMark;
  int eAddr, eData;

  task automatic modelReset();
    fCnt = 0; sCnt = 0; run = 0; swPrev = 0;
    eWrEn = 0; eFS = 0; eSS = 0; eFull = 0; eMark = 0; eAddr = 0; eData = 0;
  endtask

  // Called at posedge+1; returns at the following posedge+1
  task automatic step(input bit sw, input bit fv, input int fd, input bit sv, input int sd);
    bit swap, fWant, sWant, gf, gs;
    int word;
    iSwitch = sw; iFastVal = fv; iFastData = 12'(fd); iSlowVal = sv; iSlowData = 12'(sd);
    swap  = (sw != swPrev);
    fWant = fv && (fCnt < FAST);
    sWant = sv && (sCnt < SLOW);
    gs = !swap && sWant && (!fWant || run >= STARVE - 1);
    gf = !swap && fWant && !gs;
    #2;
    check("fastRdy", int'(oFastRdy), int'(gf));
    check("slowRdy", int'(oSlowRdy), int'(gs));
    check("wrEn", int'(oWrEn), int'(eWrEn));
    if (eWrEn) begin
      check("wrAddr", int'(oWrAddr), eAddr);
      check("wrData", int'(oWrData), eData);
    end
    check("fastShort", int'(oFastShort), int'(eFS));
    check("slowShort", int'(oSlowShort), int'(eSS));
    check("full", int'(oFull), int'(eFull));
`ifdef M16_FILL_MARKER_EN
    check("markErr", int'(oMarkErr), int'(eMark));
`endif
    @(posedge iClkOrb); #1;
    word  = gs ? (sd & 'hFFF) : (fd & 'hFFF);
    eWrEn = gf || gs;
    eAddr = (swPrev ? 0 : 2048) + (gs ? FAST + sCnt : fCnt);
`ifdef M16_FILL_MARKER_EN
    eData = word & 'h7FF;
    eMark = eWrEn && (word >= 'h800);
`else
    eData = word;
    eMark = 0;
`endif
    eFS = swap && (fCnt < FAST);
    eSS = swap && (sCnt < SLOW);
    if (swap) begin
      fCnt = 0; sCnt = 0; run = 0;
    end else if (gf) begin
      fCnt++;
      run = sWant ? run + 1 : 0;
    end else if (gs) begin
      sCnt++;
      run = 0;
    end else begin
      run = 0;
    end
    swPrev = sw;
    eFull  = (fCnt == FAST) && (sCnt == SLOW);
  endtask

  task automatic doReset(input bit sw);
    reset = 1'b0; iSwitch = sw; iFastVal = 1'b1; iSlowVal = 1'b1;
    @(posedge iClkOrb); #1;
    @(posedge iClkOrb); #1;
    check("rstFastRdy", int'(oFastRdy), 0);
    check("rstSlowRdy", int'(oSlowRdy), 0);
    check("rstWrEn", int'(oWrEn), 0);
    check("rstWrAddr", int'(oWrAddr), 0);
    check("rstShorts", int'({oFastShort, oSlowShort}), 0);
    check("rstFull", int'(oFull), 0);
    reset = 1'b1;
    modelReset();
  endtask

  typedef struct {
    bit sw; bit fv; int fd; bit sv; int sd;
    bit eFR; bit eSR; bit eWE; int eA; int eD;
  } vec_t;
  vec_t tbl[11];

  initial begin
    tbl[0]  = '{0, 1, 'h123, 0, 'h000, 1, 0, 0, 'h000, 'h000};
    tbl[1]  = '{0, 1, 'h124, 1, 'h0AA, 1, 0, 1, 'h800, 'h123};
    tbl[2]  = '{0, 1, 'h125, 1, 'h0AA, 1, 0, 1, 'h801, 'h124};
    tbl[3]  = '{0, 1, 'h126, 1, 'h0AA, 1, 0, 1, 'h802, 'h125};
    tbl[4]  = '{0, 1, 'h127, 1, 'h0AA, 0, 1, 1, 'h803, 'h126};
    tbl[5]  = '{0, 0, 'h000, 1, 'h0AB, 0, 1, 1, 'hE00, 'h0AA};
    tbl[6]  = '{0, 0, 'h000, 0, 'h000, 0, 0, 1, 'hE01, 'h0AB};
    tbl[7]  = '{0, 0, 'h000, 0, 'h000, 0, 0, 0, 'h000, 'h000};
    tbl[8]  = '{1, 1, 'h200, 1, 'h0AA, 0, 0, 0, 'h000, 'h000};
    tbl[9]  = '{1, 1, 'h200, 0, 'h000, 1, 0, 0, 'h000, 'h000};
    tbl[10] = '{1, 0, 'h000, 0, 'h000, 0, 0, 1, 'h000, 'h200};

    doReset(0);
    for (int i = 0; i < 11; i++) begin
      iSwitch = tbl[i].sw; iFastVal = tbl[i].fv; iFastData = 12'(tbl[i].fd);
      iSlowVal = tbl[i].sv; iSlowData = 12'(tbl[i].sd);
      #2;
      check($sformatf("vec%0d.fastRdy", i), int'(oFastRdy), int'(tbl[i].eFR));
      check($sformatf("vec%0d.slowRdy", i), int'(oSlowRdy), int'(tbl[i].eSR));
      check($sformatf("vec%0d.wrEn", i), int'(oWrEn), int'(tbl[i].eWE));
      if (tbl[i].eWE) begin
        check($sformatf("vec%0d.wrAddr", i), int'(oWrAddr), tbl[i].eA);
        check($sformatf("vec%0d.wrData", i), int'(oWrData), tbl[i].eD);
      end
      @(posedge iClkOrb); #1;
    end

    // Fast-only fill of the whole fast region
    doReset(0);
    for (int i = 0; i < FAST + 4; i++) step(0, 1, $urandom_range(0, 'h7FF), 0, 0);
    check("fastOnlyRdyAfterFill", int'(oFastRdy), 0);
    check("fastOnlyNotFull", int'(oFull), 0);

    // Both producers continuously valid until both regions fill
    doReset(0);
    for (int i = 0; i < 2048 + 8; i++) step(0, 1, $urandom_range(0, 'h7FF), 1, $urandom_range(0, 'h7FF));
    check("bothFull", int'(oFull), 1);

    // Swap while both regions are full: no short pulses, full drops
    step(1, 0, 0, 0, 0);
    check("fullSwapFastShort", int'(oFastShort), 0);
    check("fullSwapSlowShort", int'(oSlowShort), 0);
    check("fullDropsAfterSwap", int'(oFull), 0);
    step(1, 0, 0, 0, 0);

    // Swap after 100 fast words
    doReset(0);
    for (int i = 0; i < 100; i++) step(0, 1, i, 0, 0);
    step(1, 1, 'h3C, 0, 0);
    check("partSwapFastShort", int'(oFastShort), 1);
    check("partSwapSlowShort", int'(oSlowShort), 1);
    step(1, 1, 'h3C, 0, 0);
    check("firstNewBankAddr", int'(oWrAddr), 'h000);
    for (int i = 0; i < 4; i++) step(1, 1, i, 1, i);

    // Reset released with iSwitch already high
    doReset(1);
    step(1, 1, 'h111, 1, 'h222);
    check("rstSwapFastShort", int'(oFastShort), 1);
    check("rstSwapSlowShort", int'(oSlowShort), 1);
    step(1, 1, 'h111, 0, 0);
    check("rstSwapFirstBank", int'(oWrAddr[11]), 0);

`ifdef M16_FILL_MARKER_EN
    step(1, 0, 0, 1, 'hFFF);
    step(1, 0, 0, 0, 0);
    check("markerStrip", int'(oWrData), 'h7FF);
`endif

    // Randomized traffic, including swaps and a mid-fill reset
    doReset(0);
    for (int i = 0; i < 3000; i++) begin
      bit sw;
      sw = ($urandom_range(0, 299) == 0) ? !swPrev : swPrev;
      if (i == 1500) begin
        doReset(sw);
      end
      step(sw, ($urandom_range(0, 3) != 0), $urandom_range(0, 'hFFF),
           ($urandom_range(0, 2) == 0), $urandom_range(0, 'hFFF));
    end
    for (int i = 0; i < 2200; i++) begin
      step(swPrev, ($urandom_range(0, 1) == 0), $urandom_range(0, 'hFFF),
           ($urandom_range(0, 1) == 0), $urandom_range(0, 'hFFF));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
